// File: rtl/mcu.sv
// mcu: register-file ALU with single-cycle ops and an iterative mul/shl/shr engine.
// States: IDLE accepts opcodes | BUSY iterates mul/shift | DONE holds result until op changes
module mcu #(
  parameter int op_sz  = 32,
  parameter int mem_sz = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [mem_sz-1:0] op0_i,
  input  logic [op_sz-1:0]  op1_i,
  input  logic [mem_sz-1:0] op2_i,
  input  logic [3:0]        op_i,
  output logic [op_sz-1:0]  out_o,
  output logic              op_err_o,
  output logic              op_done_o
);

  localparam int DEPTH = 1 << mem_sz;
  localparam int CW    = $clog2(op_sz + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(op_sz - 1);
  localparam logic [op_sz-1:0] SZ      = op_sz'(op_sz);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_XOR = 4'd6,  OP_RD  = 4'd7;
  localparam logic [3:0] OP_WR  = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_ASR = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [op_sz-1:0] mem_q [DEPTH];
  state_t           state_q;
  logic [op_sz-1:0] out_q, a_q, b_q, acc_q;
  logic             err_q, done_q, noshift_q;
  logic [CW-1:0]    cnt_q;
  logic [mem_sz-1:0] dst_q;
  logic [3:0]       opc_q;

  logic [op_sz-1:0] a, b;
  assign a = mem_q[op0_i];
  assign b = mem_q[op1_i[mem_sz-1:0]];

  logic is_multi, accept;
  assign is_multi = (op_i == OP_MUL) || (op_i == OP_SHL) || (op_i == OP_SHR);
  assign accept   = (state_q == IDLE) || ((state_q == DONE) && (op_i != opc_q));

  // single-cycle datapath: result, whether it lands in mem[op2]/out, and the new error flag
  logic [op_sz-1:0] sc_res;
  logic             sc_wr, sc_out, sc_err;
  always_comb begin
    sc_res = '0;
    sc_wr  = 1'b0;
    sc_out = 1'b0;
    sc_err = 1'b0;
    case (op_i)
      OP_ADD: begin sc_res = a + b; sc_wr = 1'b1; sc_out = 1'b1; end
      OP_SUB: begin sc_res = a - b; sc_wr = 1'b1; sc_out = 1'b1; end
      OP_DIV: begin
        sc_res = (b == '0) ? '1 : a / b;
        sc_err = (b == '0);
        sc_wr  = 1'b1;
        sc_out = 1'b1;
      end
      OP_OR:  begin sc_res = a | b; sc_wr = 1'b1; sc_out = 1'b1; end
      OP_AND: begin sc_res = a & b; sc_wr = 1'b1; sc_out = 1'b1; end
      OP_XOR: begin sc_res = a ^ b; sc_wr = 1'b1; sc_out = 1'b1; end
      OP_ASR: begin
        sc_res = (b >= SZ) ? {op_sz{a[op_sz-1]}} : $unsigned($signed(a) >>> b);
        sc_wr  = 1'b1;
        sc_out = 1'b1;
      end
      OP_RD:  begin sc_res = a; sc_out = 1'b1; end
      OP_WR, OP_MUL, OP_SHL, OP_SHR: sc_err = 1'b0;
      default: sc_err = 1'b1;
    endcase
  end

  logic [op_sz-1:0] mul_acc_n, shift_n, busy_res;
  logic             last;
  assign mul_acc_n = acc_q + (b_q[0] ? a_q : '0);
  assign shift_n   = (opc_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
  assign busy_res  = (opc_q == OP_MUL) ? mul_acc_n : (noshift_q ? a_q : shift_n);
  assign last      = (cnt_q == '0);

  logic              mem_we;
  logic [mem_sz-1:0] mem_wa;
  logic [op_sz-1:0]  mem_wd;
  always_comb begin
    mem_we = 1'b0;
    mem_wa = op2_i;
    mem_wd = sc_res;
    if (!rst_i) begin
      if (state_q == BUSY) begin
        if (last) begin
          mem_we = 1'b1;
          mem_wa = dst_q;
          mem_wd = busy_res;
        end
      end else if (accept) begin
        if (op_i == OP_WR) begin
          mem_we = 1'b1;
          mem_wa = op0_i;
          mem_wd = op1_i;
        end else if (sc_wr) begin
          mem_we = 1'b1;
        end
      end
    end
  end

  // memory is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  logic [CW-1:0] shift_cnt;
  assign shift_cnt = (b == '0) ? '0 : ((b >= SZ) ? CNT_MAX : (b[CW-1:0] - CW'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      out_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      noshift_q <= 1'b0;
      dst_q     <= '0;
      opc_q     <= '0;
    end else begin
      case (state_q)
        BUSY: begin
          if (opc_q == OP_MUL) begin
            acc_q <= mul_acc_n;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else if (!noshift_q) begin
            a_q <= shift_n;
          end
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            state_q <= DONE;
            out_q   <= busy_res;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (state_q == IDLE && is_multi) begin
            state_q   <= BUSY;
            err_q     <= 1'b0;
            opc_q     <= op_i;
            dst_q     <= op2_i;
            a_q       <= a;
            b_q       <= b;
            acc_q     <= '0;
            noshift_q <= (op_i != OP_MUL) && (b == '0);
            cnt_q     <= (op_i == OP_MUL) ? CNT_MAX : shift_cnt;
          end else if (accept) begin
            if (state_q == DONE) begin
              state_q <= IDLE;
              done_q  <= 1'b0;
            end
            if (!is_multi) begin
              if (sc_out) out_q <= sc_res;
              err_q <= sc_err;
            end
          end
        end
      endcase
    end
  end

  assign out_o     = out_q;
  assign op_err_o  = err_q;
  assign op_done_o = done_q;

endmodule

// File: tb/tb_mcu.sv
// Directed self-checking bench for mcu: ALU ops, multi-cycle engine, error flag and reset behaviour.
module tb_mcu;

  logic        clk, rst;
  logic [7:0]  op0, op2;
  logic [31:0] op1;
  logic [3:0]  op;
  logic [31:0] out;
  logic        op_err, op_done;
  int          checks, errors;
  int          n;

  mcu #(.op_sz(32), .mem_sz(8)) dut (
    .clk_i(clk), .rst_i(rst), .op0_i(op0), .op1_i(op1), .op2_i(op2), .op_i(op),
    .out_o(out), .op_err_o(op_err), .op_done_o(op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] o, input logic [7:0] a0, input logic [31:0] a1,
                      input logic [7:0] a2);
    op = o; op0 = a0; op1 = a1; op2 = a2;
    @(posedge clk); #1;
  endtask

  // Reset pulse with a write pending, which must not execute while reset is high
  task automatic reset_pulse();
    op = 4'd8; op0 = 8'd5; op1 = 32'd99;
    rst = 1'b1;
    #1;
    check("rst_out", out, 32'd0);
    check("rst_err", {31'd0, op_err}, 32'd0);
    check("rst_done", {31'd0, op_done}, 32'd0);
    @(posedge clk); #1;
    op = 4'd7; op0 = 8'd5;
    rst = 1'b0;
  endtask

  // Start a multi-cycle op and count edges until op_done; optionally scramble inputs after start
  task automatic run_multi(input logic [3:0] o, input logic [7:0] a0, input logic [31:0] a1,
                           input logic [7:0] a2, input bit scramble, output int cnt);
    op = o; op0 = a0; op1 = a1; op2 = a2;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cnt = i + 1;
      if (i == 0 && scramble) begin
        op0 = 8'd6; op1 = 32'd7; op2 = 8'd20;
      end
      if (op_done) break;
    end
    check("done_seen", {31'd0, op_done}, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    op = 4'd8; op0 = 8'd0; op1 = 32'd65; op2 = 8'd0;
    #2 rst = 1'b1;
    #1;
    check("init_out", out, 32'd0);
    check("init_err", {31'd0, op_err}, 32'd0);
    check("init_done", {31'd0, op_done}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    step(4'd8, 8'd0, 32'd65, 8'd0);
    step(4'd8, 8'd5, 32'd12, 8'd0);
    step(4'd8, 8'd6, 32'd15, 8'd0);
    step(4'd8, 8'd1, 32'd3, 8'd0);
    step(4'd8, 8'd7, 32'd0, 8'd0);
    step(4'd8, 8'd17, 32'd77, 8'd0);
    step(4'd8, 8'd2, 32'h8000_0010, 8'd0);
    step(4'd8, 8'd3, 32'd40, 8'd0);
    check("write_keeps_out", out, 32'd0);

    step(4'd0, 8'd5, 32'd6, 8'd12);   check("add", out, 32'd27);
    step(4'd7, 8'd12, 32'd0, 8'd0);   check("rd_add", out, 32'd27);
    step(4'd1, 8'd6, 32'd5, 8'd11);   check("sub", out, 32'd3);
    step(4'd7, 8'd11, 32'd0, 8'd0);   check("rd_sub", out, 32'd3);
    step(4'd3, 8'd5, 32'd1, 8'd9);    check("div", out, 32'd4);
    check("div_err", {31'd0, op_err}, 32'd0);
    step(4'd7, 8'd9, 32'd0, 8'd0);    check("rd_div", out, 32'd4);
    step(4'd4, 8'd6, 32'd1, 8'd13);   check("or", out, 32'd15);
    step(4'd7, 8'd13, 32'd0, 8'd0);   check("rd_or", out, 32'd15);
    step(4'd5, 8'd6, 32'd1, 8'd9);    check("and", out, 32'd3);
    step(4'd7, 8'd9, 32'd0, 8'd0);    check("rd_and", out, 32'd3);
    step(4'd6, 8'd5, 32'd12, 8'd8);   check("xor", out, 32'd23);
    step(4'd7, 8'd8, 32'd0, 8'd0);    check("rd_xor", out, 32'd23);
    step(4'd11, 8'd2, 32'd1, 8'd19);  check("asr_neg", out, 32'hF000_0002);
    step(4'd11, 8'd2, 32'd3, 8'd20);  check("asr_big", out, 32'hFFFF_FFFF);
    step(4'd11, 8'd0, 32'd1, 8'd21);  check("asr_pos", out, 32'd8);
    step(4'd7, 8'd19, 32'd0, 8'd0);   check("rd_asr", out, 32'hF000_0002);
    step(4'd0, 8'd12, 32'd12, 8'd12); check("add_alias", out, 32'd54);
    step(4'd7, 8'd12, 32'd0, 8'd0);   check("rd_alias", out, 32'd54);

    reset_pulse();
    run_multi(4'd9, 8'd5, 32'd1, 8'd14, 1'b1, n);
    check("shl_cycles", n, 32'd4);
    check("shl", out, 32'd96);
    @(posedge clk); #1;
    check("done_hold", {31'd0, op_done}, 32'd1);
    step(4'd7, 8'd14, 32'd0, 8'd0);   check("rd_shl", out, 32'd96);
    check("done_clear", {31'd0, op_done}, 32'd0);
    run_multi(4'd10, 8'd6, 32'd1, 8'd15, 1'b0, n);
    check("shr_cycles", n, 32'd4);
    check("shr", out, 32'd1);
    step(4'd7, 8'd15, 32'd0, 8'd0);   check("rd_shr", out, 32'd1);
    run_multi(4'd9, 8'd5, 32'd7, 8'd18, 1'b0, n);
    check("shl0_cycles", n, 32'd2);
    check("shl0", out, 32'd12);
    step(4'd7, 8'd18, 32'd0, 8'd0);   check("rd_shl0", out, 32'd12);

    reset_pulse();
    run_multi(4'd2, 8'd1, 32'd0, 8'd10, 1'b0, n);
    check("mul_cycles", n, 32'd33);
    check("mul", out, 32'd195);
    step(4'd7, 8'd10, 32'd0, 8'd0);   check("rd_mul", out, 32'd195);
    step(4'd7, 8'd5, 32'd0, 8'd0);    check("mem5_kept", out, 32'd12);
    step(4'd7, 8'd6, 32'd0, 8'd0);    check("mem6_kept", out, 32'd15);

    step(4'd14, 8'd5, 32'd0, 8'd5);
    check("inv_err", {31'd0, op_err}, 32'd1);
    check("inv_out", out, 32'd15);
    step(4'd7, 8'd5, 32'd0, 8'd0);    check("inv_mem", out, 32'd12);
    check("inv_clear", {31'd0, op_err}, 32'd0);
    step(4'd3, 8'd5, 32'd7, 8'd16);
    check("div0_out", out, 32'hFFFF_FFFF);
    check("div0_err", {31'd0, op_err}, 32'd1);
    step(4'd7, 8'd16, 32'd0, 8'd0);   check("rd_div0", out, 32'hFFFF_FFFF);
    check("div0_clear", {31'd0, op_err}, 32'd0);

    // mid-mul: a write presented while busy must be ignored, reset aborts the result
    op = 4'd2; op0 = 8'd1; op1 = 32'd0; op2 = 8'd17;
    @(posedge clk); #1;
    op = 4'd8; op0 = 8'd17; op1 = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("busy_done", {31'd0, op_done}, 32'd0);
    reset_pulse();
    step(4'd7, 8'd17, 32'd0, 8'd0);   check("abort_mem", out, 32'd77);
    step(4'd7, 8'd5, 32'd0, 8'd0);    check("rst_no_write", out, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu.md
MCU -- requirements
Module: mcu

Interface
REQ-001 op_sz, default 32: data word width.
REQ-002 mem_sz, default 8: address width; the register file depth SHALL be 2^mem_sz words of op_sz bits.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1: reset is asynchronous and active-high.
REQ-005 op0  input  mem_sz: address of source A, the read address, or the write address.
REQ-006 op1  input  op_sz: low mem_sz bits give the address of source B; for write, the full op1 is the data.
REQ-007 op2  input  mem_sz: destination address for computed results.
REQ-008 op  input  4: opcode.
REQ-009 out  output  op_sz: registered result or read data.
REQ-010 op_err  output  1: registered invalid-opcode or divide-by-zero flag.
REQ-011 op_done  output  1: completion flag for multi-cycle operations.
REQ-012 Port order SHALL be clk, reset, op0, op1, op2, op, out, op_err, op_done; parameter order SHALL be op_sz, mem_sz.

Function
REQ-013 Notation: A = mem[op0] and B = mem[op1[mem_sz-1:0]]; all results SHALL be truncated to op_sz bits, unsigned unless stated.
REQ-014 Single-cycle opcodes SHALL write mem[op2] and out at the next rising edge:
- 0 add: A+B
- 1 sub: A-B, modulo 2^op_sz
- 3 div: A/B, integer quotient
- 4 or: A|B
- 5 and: A&B
- 6 xor: A^B
- 11 asr: signed A >>> B; if B >= op_sz, every bit SHALL equal the sign bit.
REQ-015 Opcode 7 read SHALL set out = mem[op0] at the next edge, with no memory write.
REQ-016 Opcode 8 write SHALL set mem[op0] = op1 at the next edge; out SHALL be unchanged.
REQ-017 Multi-cycle opcodes 2 mul (A*B, low op_sz bits), 9 shl (A<<B) and 10 shr (A>>B, logical) SHALL use an FSM with states IDLE, BUSY and DONE.
REQ-018 IDLE->BUSY SHALL occur on the first edge after reset release with op in {2,9,10}; on that edge A, B, op2 and the opcode SHALL be latched, so later input changes SHALL not affect the operation.
REQ-019 mul SHALL be iterative shift-add over exactly op_sz cycles in BUSY.
REQ-020 shl/shr SHALL shift one bit per cycle for min(B, op_sz) cycles; B = 0 SHALL spend one BUSY cycle.
REQ-021 BUSY->DONE SHALL write the result to mem[latched op2], set out = result, and set op_done = 1.
REQ-022 In DONE, op_done SHALL stay 1 and no operation SHALL restart while op is unchanged.
REQ-023 DONE->IDLE SHALL occur on reset or when op changes; op_done SHALL clear on that transition.
REQ-024 Opcodes 12-15 SHALL set op_err = 1 at the next edge, with no memory write and out unchanged.
REQ-025 Div with B = 0 SHALL write all-ones to mem[op2] and out, and SHALL set op_err = 1.
REQ-026 op_err SHALL clear at the edge that accepts any valid opcode.
REQ-027 Single-cycle opcodes SHALL be ignored while the FSM is BUSY.
REQ-028 If op2 equals a source address, the sources SHALL be read before the write (old value used).

Reset
REQ-029 Reset SHALL immediately force out = 0, op_err = 0, op_done = 0, and FSM = IDLE.
REQ-030 Reset SHALL NOT clear memory contents; memory power-up contents are undefined.
REQ-031 Reset asserted during BUSY SHALL abort the operation with no memory write.
REQ-032 No operation, including write, SHALL execute on an edge while reset is high.

Verification
REQ-033 Setup: write 12@5, 15@6, 65@0, 3@1.
- add(op0=5, op1=6, op2=12), then read 12 -> out = 27.
- sub(6, 5 -> 11), then read 11 -> out = 3.
REQ-034 div(5, 1 -> 9) -> read 9 gives 4.
- or(6, 1 -> 13) -> read 13 gives 15.
- and(6, 1 -> 9) -> read 9 gives 3.
- xor(5, 12 -> 8) -> read 8 gives 23.
REQ-035 Pulse reset, then shl(5, 1 -> 14) -> op_done rises; read 14 gives 96.
- shr(6, 1 -> 15) -> read 15 gives 1.
REQ-036 Pulse reset, then mul(1, 0 -> 10) -> op_done rises after op_sz+1 cycles; read 10 gives 195; memory addresses 5 and 6 are unchanged across the reset pulses.
REQ-037 op = 14 -> op_err = 1 next edge with memory unchanged.
- Div with B = 0 -> all-ones result and op_err = 1.
- A following valid op -> op_err = 0.
REQ-038 Reset asserted mid-mul -> op_done = 0 and the destination word keeps its old value.
